act_tile_loader: RTL and testbench

Upstream feeder for the skewed activation shift buffer. Accepts activation bytes as a valid/ready stream and assembles them into a 16-entry tile. Presents the tile on a parallel bus with a one-cycle `load` pulse, then holds off the next load until the shift buffer has finished draining the previous tile into the systolic array. Optionally double-buffers, so the next tile fills while the current one drains.

---
 rtl/act_loader_pkg.sv | 8 +
 rtl/act_tile_bank.sv | 40 ++++
 rtl/act_tile_loader.sv | 68 ++++++
 tb/tb_act_tile_loader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/act_loader_pkg.sv
// act_loader_pkg: shared constants, FSM state type and activation type for the tile loader
package act_loader_pkg;
  localparam int ACT_DATA_W = 8;
  localparam int ACT_TILE = 16;
  localparam int ACT_DRAIN_CYCLES = 7;
  typedef enum logic [1:0] {FILL, LOAD, DRAIN} act_ld_state_t;
  typedef logic [ACT_DATA_W-1:0] act_t;
endpackage

// File: rtl/act_tile_bank.sv
// act_tile_bank: fill buffer with indexed write, sync clear, complete flag and write-through read-out
module act_tile_bank #(
  parameter int DATA_W = 8,
  parameter int TILE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  input  logic              clr,
  output logic              complete,
  output logic              done,
  output logic [DATA_W-1:0] tile [TILE-1:0]
);
  localparam int IW = TILE > 1 ? $clog2(TILE) : 1;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] mem [TILE-1:0];
  assign done = we && (idx == IW'(TILE-1) || wlast);
  // read-out includes this cycle's byte so a completing transfer lands in the snapshot
  always_comb begin
    for (int i = 0; i < TILE; i++) tile[i] = (we && idx == IW'(i)) ? wdata : mem[i];
  end
  // clear wins over a simultaneous write: the completing byte is already in the snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      complete <= 1'b0;
      mem <= '{default: '0};
    end else if (clr) begin
      idx <= '0;
      complete <= 1'b0;
      mem <= '{default: '0};
    end else if (we) begin
      mem[idx] <= wdata;
      idx <= done ? '0 : idx + 1'b1;
      complete <= done;
    end
  end
endmodule

// File: rtl/act_tile_loader.sv
// act_tile_loader: assembles a byte stream into tiles and issues them to the shift buffer;
// define ACT_LOADER_DBUF_EN to let the next tile fill while the current one drains
import act_loader_pkg::*;

module act_tile_loader #(
  parameter int DATA_W = ACT_DATA_W,
  parameter int TILE = ACT_TILE,
  parameter int DRAIN_CYCLES = ACT_DRAIN_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              load,
  output logic [DATA_W-1:0] activation [TILE-1:0],
  output logic              busy,
  output logic [15:0]       tiles_issued
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  act_ld_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic complete, done, enter_load;
  logic [DATA_W-1:0] snap [TILE-1:0];
  act_tile_bank #(.DATA_W(DATA_W), .TILE(TILE)) u_bank (
    .clk(clk),
    .reset(reset),
    .we(in_valid && in_ready),
    .wdata(in_data),
    .wlast(in_last),
    .clr(enter_load),
    .complete(complete),
    .done(done),
    .tile(snap)
  );
`ifdef ACT_LOADER_DBUF_EN
  assign in_ready = reset && !complete;
`else
  assign in_ready = reset && state == FILL && !complete;
`endif
  assign busy = state != FILL;
  assign enter_load = state == FILL && state_nxt == LOAD;
  // next state: issue on completion or a held tile, one load cycle, then a counted drain
  always_comb begin
    state_nxt = state == FILL ? ((done || complete) ? LOAD : FILL)
              : state == LOAD ? DRAIN
              : (cnt == '0 ? FILL : DRAIN);
  end
  // state, drain counter, load strobe and the presented tile
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      cnt <= '0;
      load <= 1'b0;
      tiles_issued <= '0;
      activation <= '{default: '0};
    end else begin
      state <= state_nxt;
      load <= state_nxt == LOAD;
      cnt <= state == LOAD ? CW'(DRAIN_CYCLES - 1) : (state == DRAIN && cnt != '0) ? cnt - 1'b1 : cnt;
      if (enter_load) begin
        tiles_issued <= tiles_issued + 1'b1;
        activation <= snap;
      end
    end
  end
endmodule

// File: tb/tb_act_tile_loader.sv
// tb_act_tile_loader: directed and random checks of act_tile_loader against a timing-rule model
module tb_act_tile_loader;
  import act_loader_pkg::*;
  localparam int W = ACT_DATA_W;
  localparam int T = ACT_TILE;
  localparam int D = ACT_DRAIN_CYCLES;
`ifdef ACT_LOADER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic in_last = 1'b0;
  logic load, busy;
  logic [W-1:0] activation [T-1:0];
  logic [15:0] tiles_issued;

  act_tile_loader dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .load(load),
    .activation(activation),
    .busy(busy),
    .tiles_issued(tiles_issued)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_load = -100;
  logic [W-1:0] fill_q [$];
  logic [W-1:0] held_tile [T];
  logic [W-1:0] act_exp [T];
  bit held = 1'b0;
  logic [15:0] issued = '0;
  int loads [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    fill_q.delete();
    held = 1'b0;
    last_load = -100;
    issued = '0;
    foreach (act_exp[i]) act_exp[i] = '0;
  endtask

  // one clock: drive inputs, compare every output with the model, then advance the model
  task automatic step(input bit r, input bit v, input logic [W-1:0] d, input bit l, output bit took);
    bit bsy, rdy;
    @(negedge clk);
    reset = r;
    in_valid = v;
    in_data = d;
    in_last = l;
    if (!r) model_reset();
    bsy = r && (cyc - last_load) >= 0 && (cyc - last_load) <= D;
    rdy = r && !held && (DBUF || !bsy);
    #1;
    chk("load", load, cyc == last_load);
    chk("busy", busy, bsy);
    chk("in_ready", in_ready, rdy);
    chk("tiles_issued", tiles_issued, issued);
    for (int i = 0; i < T; i++) chk($sformatf("activation[%0d]", i), activation[i], act_exp[i]);
    if (load === 1'b1) loads.push_back(cyc);
    took = r && v && rdy;
    @(posedge clk);
    if (took) begin
      fill_q.push_back(d);
      if (fill_q.size() == T || l) begin
        foreach (held_tile[i]) held_tile[i] = (i < fill_q.size()) ? fill_q[i] : '0;
        fill_q.delete();
        held = 1'b1;
      end
    end
    if (r && held && !bsy) begin
      last_load = cyc + 1;
      act_exp = held_tile;
      held = 1'b0;
      issued++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, t);
  endtask

  initial begin
    bit t;
    int t0, sent;
    #1 reset = 1'b0;
    // reset held with valid asserted
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF, 1'b0, t);
    idle(1);
    // full tile
    loads.delete();
    t0 = cyc;
    for (int i = 0; i < T; i++) step(1'b1, 1'b1, W'(i + 1), 1'b0, t);
    idle(12);
    chk("full_load_count", loads.size(), 1);
    if (loads.size() > 0) chk("full_load_cycle", loads[0], t0 + 16);
    chk("full_act15", activation[15], 8'h10);
    // short tile
    loads.delete();
    t0 = cyc;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, W'(8'hA0 + i), i == 4, t);
    idle(12);
    chk("short_load_count", loads.size(), 1);
    if (loads.size() > 0) chk("short_load_cycle", loads[0], t0 + 5);
    chk("short_act4", activation[4], 8'hA4);
    chk("short_act5", activation[5], 8'h00);
    // bubbles
    loads.delete();
    t0 = cyc;
    for (int i = 0; i < 32; i++) step(1'b1, i % 2 == 0, W'(8'h40 + i / 2), 1'b0, t);
    idle(12);
    chk("bubble_load_count", loads.size(), 1);
    if (loads.size() > 0) chk("bubble_load_cycle", loads[0], t0 + 31);
    // mid-fill reset
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, W'(8'h90 + i), 1'b0, t);
    step(1'b0, 1'b1, 8'h55, 1'b0, t);
    step(1'b0, 1'b0, 8'h55, 1'b0, t);
    loads.delete();
    for (int i = 0; i < T; i++) step(1'b1, 1'b1, W'(8'h20 + i), 1'b0, t);
    idle(12);
    chk("midrst_load_count", loads.size(), 1);
    chk("midrst_issued", tiles_issued, 1);
    for (int i = 0; i < T; i++) chk($sformatf("midrst_act[%0d]", i), activation[i], W'(8'h20 + i));
    // back-to-back tiles
    step(1'b0, 1'b0, '0, 1'b0, t);
    loads.delete();
    t0 = cyc;
    sent = 0;
    for (int n = 0; n < 300 && sent < 32; n++) begin
      step(1'b1, 1'b1, W'(sent + 1), 1'b0, t);
      if (t) sent++;
    end
    idle(12);
    chk("b2b_sent", sent, 32);
    chk("b2b_load_count", loads.size(), 2);
    if (loads.size() > 1) begin
      chk("b2b_load0", loads[0], t0 + 16);
      chk("b2b_load1", loads[1], t0 + (DBUF ? 32 : 40));
    end
    chk("b2b_issued", tiles_issued, 2);
    // randomized traffic with occasional short tiles and resets
    for (int n = 0; n < 1500; n++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 15) == 0, t);
    idle(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
